// File: rtl/median_stream_capture_if.sv
// Stream-in and frame-read bundle for the median filter capture sink.
interface median_stream_capture_if #(
    parameter int WORD_LEN = 8,
    parameter int ADDR_W   = 6,
    parameter int CNT_W    = 16
);
    logic [WORD_LEN-1:0] dat_i;
    logic                val_i;
    logic                clr;
    logic                rd_en;
    logic [WORD_LEN-1:0] rd_dat;
    logic                rd_val;
    logic                frm_rdy;
    logic [ADDR_W:0]     frm_len;
    logic                ovf;
    logic [CNT_W-1:0]    frm_cnt;
    logic [CNT_W-1:0]    drop_cnt;

    modport slave (
        input  dat_i, val_i, clr, rd_en,
        output rd_dat, rd_val, frm_rdy, frm_len, ovf, frm_cnt, drop_cnt
    );

    modport master (
        output dat_i, val_i, clr, rd_en,
        input  rd_dat, rd_val, frm_rdy, frm_len, ovf, frm_cnt, drop_cnt
    );
endinterface

// File: rtl/median_stream_capture.sv
// Captures one contiguous valid burst from the median filter stream,
// holds it, and lets a reader drain it word-by-word before re-arming.
module median_stream_capture #(
    parameter int WORD_LEN = 8,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 6,
    parameter int CNT_W    = 16
) (
    input logic                   clk,
    input logic                   rst,
    median_stream_capture_if.slave s
);
    typedef enum logic [1:0] {IDLE, CAPT, HOLD, DRAIN} state_t;

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] PTR_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     wptr_q, wptr_d;
    logic [ADDR_W:0]     rptr_q, rptr_d;
    logic [ADDR_W:0]     frm_len_q, frm_len_d;
    logic                frm_rdy_q, frm_rdy_d;
    logic                ovf_q, ovf_d;
    logic [CNT_W-1:0]    frm_cnt_q, frm_cnt_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic [WORD_LEN-1:0] rd_dat_q, rd_dat_d;
    logic                rd_val_q, rd_val_d;
    logic                val_prev_q;

    logic [WORD_LEN-1:0] mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;

    logic rise;
    logic rd_acc;
    logic last_rd;

    // Capture only starts on a fresh rising edge, never mid-burst.
    assign rise    = s.val_i & ~val_prev_q;
    assign rd_acc  = s.rd_en & frm_rdy_q & (rptr_q < frm_len_q);
    assign last_rd = (rptr_q + PTR_ONE) == frm_len_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            frm_len_q  <= '0;
            frm_rdy_q  <= 1'b0;
            ovf_q      <= 1'b0;
            frm_cnt_q  <= '0;
            drop_cnt_q <= '0;
            rd_dat_q   <= '0;
            rd_val_q   <= 1'b0;
            val_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            frm_len_q  <= frm_len_d;
            frm_rdy_q  <= frm_rdy_d;
            ovf_q      <= ovf_d;
            frm_cnt_q  <= frm_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            rd_dat_q   <= rd_dat_d;
            rd_val_q   <= rd_val_d;
            val_prev_q <= s.val_i;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_wa] <= s.dat_i;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:        if (rise) state_d = CAPT;
            CAPT:        if (!s.val_i) state_d = HOLD;
            HOLD, DRAIN: if (rd_acc) state_d = last_rd ? IDLE : DRAIN;
            default:     state_d = IDLE;
        endcase
        if (s.clr) state_d = IDLE;
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        frm_len_d  = frm_len_q;
        frm_rdy_d  = frm_rdy_q;
        ovf_d      = ovf_q;
        frm_cnt_d  = frm_cnt_q;
        drop_cnt_d = drop_cnt_q;
        rd_dat_d   = rd_dat_q;
        rd_val_d   = 1'b0;
        mem_we     = 1'b0;
        mem_wa     = wptr_q[ADDR_W-1:0];
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    mem_we = 1'b1;
                    mem_wa = '0;
                    wptr_d = PTR_ONE;
                end
            end
            CAPT: begin
                if (s.val_i) begin
                    if (wptr_q < PTR_MAX) begin
                        mem_we = 1'b1;
                        wptr_d = wptr_q + PTR_ONE;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    frm_len_d = wptr_q;
                    frm_rdy_d = 1'b1;
                    frm_cnt_d = frm_cnt_q + CNT_ONE;
                end
            end
            HOLD, DRAIN: begin
                if (rise) drop_cnt_d = drop_cnt_q + CNT_ONE;
                if (rd_acc) begin
                    rd_dat_d = mem[rptr_q[ADDR_W-1:0]];
                    rd_val_d = 1'b1;
                    rptr_d   = rptr_q + PTR_ONE;
                    if (last_rd) begin
                        frm_rdy_d = 1'b0;
                        ovf_d     = 1'b0;
                        wptr_d    = '0;
                        rptr_d    = '0;
                    end
                end
            end
            default: ;
        endcase
        // Abandon wins over any read or capture activity this cycle.
        if (s.clr) begin
            mem_we     = 1'b0;
            wptr_d     = '0;
            rptr_d     = '0;
            frm_rdy_d  = 1'b0;
            ovf_d      = 1'b0;
            frm_len_d  = frm_len_q;
            frm_cnt_d  = frm_cnt_q;
            drop_cnt_d = drop_cnt_q;
            rd_dat_d   = rd_dat_q;
            rd_val_d   = 1'b0;
        end
    end

    assign s.rd_dat   = rd_dat_q;
    assign s.rd_val   = rd_val_q;
    assign s.frm_rdy  = frm_rdy_q;
    assign s.frm_len  = frm_len_q;
    assign s.ovf      = ovf_q;
    assign s.frm_cnt  = frm_cnt_q;
    assign s.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_median_stream_capture.sv
// Self-checking bench for median_stream_capture: vector table, directed
// corner sequences and a randomized run against a queue-based model.
module tb_median_stream_capture;
    localparam int DEPTH = 64;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    median_stream_capture_if #(.WORD_LEN(8), .ADDR_W(6), .CNT_W(16)) bus ();

    median_stream_capture #(
        .WORD_LEN(8), .DEPTH(DEPTH), .ADDR_W(6), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit         rs;
        bit         v;
        bit         c;
        bit         r;
        logic [7:0] d;
        bit         e_rdy;
        logic [6:0] e_len;
        bit         e_ovf;
        bit         e_rv;
        logic [7:0] e_dat;
        logic [15:0] e_fc;
    } vec_t;

    vec_t tbl [14];

    // Reference model: the frame is a queue of words.
    logic [7:0]  m_q [$];
    bit          m_cap;
    bit          m_hold;
    bit          m_prev;
    int          m_rd;
    logic [7:0]  e_dat;
    bit          e_rv;
    bit          e_rdy;
    bit          e_ovf;
    int          e_len;
    logic [15:0] e_fc;
    logic [15:0] e_dc;

    function automatic void model_reset();
        m_q.delete();
        m_cap  = 0;
        m_hold = 0;
        m_prev = 0;
        m_rd   = 0;
        e_dat  = 8'h00;
        e_rv   = 0;
        e_rdy  = 0;
        e_ovf  = 0;
        e_len  = 0;
        e_fc   = 16'h0;
        e_dc   = 16'h0;
    endfunction

    function automatic void model_step(bit v, logic [7:0] d, bit c, bit r);
        bit rise;
        rise = v && !m_prev;
        e_rv = 0;
        if (c) begin
            m_cap  = 0;
            m_hold = 0;
            e_rdy  = 0;
            e_ovf  = 0;
            m_q.delete();
        end else if (m_hold) begin
            if (rise) e_dc = e_dc + 16'h1;
            if (r) begin
                e_dat = m_q[m_rd];
                e_rv  = 1;
                m_rd++;
                if (m_rd == e_len) begin
                    m_hold = 0;
                    e_rdy  = 0;
                    e_ovf  = 0;
                    m_q.delete();
                end
            end
        end else if (m_cap) begin
            if (v) begin
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else e_ovf = 1;
            end else begin
                m_cap  = 0;
                m_hold = 1;
                e_rdy  = 1;
                e_len  = m_q.size();
                e_fc   = e_fc + 16'h1;
                m_rd   = 0;
            end
        end else if (rise) begin
            m_cap = 1;
            m_q.push_back(d);
        end
        m_prev = v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_model();
        chk("m.rd_val", 32'(bus.rd_val), 32'(e_rv));
        chk("m.rd_dat", 32'(bus.rd_dat), 32'(e_dat));
        chk("m.frm_rdy", 32'(bus.frm_rdy), 32'(e_rdy));
        chk("m.frm_len", 32'(bus.frm_len), 32'(e_len));
        chk("m.ovf", 32'(bus.ovf), 32'(e_ovf));
        chk("m.frm_cnt", 32'(bus.frm_cnt), 32'(e_fc));
        chk("m.drop_cnt", 32'(bus.drop_cnt), 32'(e_dc));
    endtask

    task automatic cyc(input bit rs, input bit v, input logic [7:0] d,
                       input bit c, input bit r);
        @(negedge clk);
        rst       = rs;
        bus.val_i = v;
        bus.dat_i = d;
        bus.clr   = c;
        bus.rd_en = r;
        @(posedge clk);
        if (rs) model_reset();
        else model_step(v, d, c, r);
        #1;
        cmp_model();
    endtask

    task automatic burst(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) cyc(0, 1, base + 8'(i), 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
    endtask

    initial begin
        bit v_r;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.val_i = 1'b0;
        bus.dat_i = 8'h00;
        bus.clr   = 1'b0;
        bus.rd_en = 1'b0;
        model_reset();

        tbl[0]  = '{1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0};
        tbl[1]  = '{0, 1, 0, 0, 8'h10, 0, 0, 0, 0, 8'h00, 0};
        tbl[2]  = '{0, 1, 0, 0, 8'h20, 0, 0, 0, 0, 8'h00, 0};
        tbl[3]  = '{0, 1, 0, 0, 8'h30, 0, 0, 0, 0, 8'h00, 0};
        tbl[4]  = '{0, 1, 0, 0, 8'h40, 0, 0, 0, 0, 8'h00, 0};
        tbl[5]  = '{0, 1, 0, 0, 8'h50, 0, 0, 0, 0, 8'h00, 0};
        tbl[6]  = '{0, 0, 0, 0, 8'h00, 1, 5, 0, 0, 8'h00, 1};
        tbl[7]  = '{0, 0, 0, 1, 8'h00, 1, 5, 0, 1, 8'h10, 1};
        tbl[8]  = '{0, 0, 0, 1, 8'h00, 1, 5, 0, 1, 8'h20, 1};
        tbl[9]  = '{0, 0, 0, 1, 8'h00, 1, 5, 0, 1, 8'h30, 1};
        tbl[10] = '{0, 0, 0, 1, 8'h00, 1, 5, 0, 1, 8'h40, 1};
        tbl[11] = '{0, 0, 0, 1, 8'h00, 0, 5, 0, 1, 8'h50, 1};
        tbl[12] = '{0, 0, 0, 0, 8'h00, 0, 5, 0, 0, 8'h50, 1};
        tbl[13] = '{0, 0, 0, 1, 8'h00, 0, 5, 0, 0, 8'h50, 1};

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].rs, tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].r);
            chk($sformatf("tbl%0d.rdy", i), 32'(bus.frm_rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d.len", i), 32'(bus.frm_len), 32'(tbl[i].e_len));
            chk($sformatf("tbl%0d.ovf", i), 32'(bus.ovf), 32'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d.rv", i), 32'(bus.rd_val), 32'(tbl[i].e_rv));
            chk($sformatf("tbl%0d.dat", i), 32'(bus.rd_dat), 32'(tbl[i].e_dat));
            chk($sformatf("tbl%0d.fc", i), 32'(bus.frm_cnt), 32'(tbl[i].e_fc));
        end

        // Overlong burst truncates at DEPTH.
        burst(70, 8'h00);
        chk("ovf.len", 32'(bus.frm_len), 32'd64);
        chk("ovf.flag", 32'(bus.ovf), 32'd1);
        chk("ovf.fc", 32'(bus.frm_cnt), 32'd2);
        for (int i = 0; i < 64; i++) begin
            cyc(0, 0, 8'h00, 0, 1);
            chk("ovf.rd", 32'(bus.rd_dat), 32'(i));
        end
        chk("ovf.clr", 32'(bus.ovf), 32'd0);
        chk("ovf.rdy", 32'(bus.frm_rdy), 32'd0);

        // Bursts arriving while held are dropped.
        burst(3, 8'hA1);
        burst(3, 8'hB0);
        burst(3, 8'hC0);
        chk("drop.cnt", 32'(bus.drop_cnt), 32'd2);
        chk("drop.len", 32'(bus.frm_len), 32'd3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 0, 1);
        chk("drop.last", 32'(bus.rd_dat), 32'hA3);
        burst(1, 8'hAA);
        chk("one.len", 32'(bus.frm_len), 32'd1);
        chk("one.fc", 32'(bus.frm_cnt), 32'd4);
        cyc(0, 0, 8'h00, 0, 1);
        chk("one.dat", 32'(bus.rd_dat), 32'hAA);
        chk("one.rdy", 32'(bus.frm_rdy), 32'd0);

        // Burst begun during HOLD must not be captured after drain.
        burst(2, 8'h61);
        cyc(0, 1, 8'hE0, 0, 0);
        cyc(0, 1, 8'hE1, 0, 1);
        cyc(0, 1, 8'hE2, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'hE3, 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
        chk("late.rdy", 32'(bus.frm_rdy), 32'd0);
        chk("late.fc", 32'(bus.frm_cnt), 32'd5);
        burst(2, 8'h5A);
        chk("fresh.rdy", 32'(bus.frm_rdy), 32'd1);
        chk("fresh.len", 32'(bus.frm_len), 32'd2);
        chk("fresh.drop", 32'(bus.drop_cnt), 32'd3);
        cyc(0, 0, 8'h00, 0, 1);
        cyc(0, 0, 8'h00, 0, 1);
        chk("fresh.dat", 32'(bus.rd_dat), 32'h5B);

        // clr mid-capture, with a read request in the same cycle.
        cyc(0, 1, 8'h71, 0, 0);
        cyc(0, 1, 8'h72, 0, 0);
        cyc(0, 1, 8'h73, 1, 1);
        chk("clr.rv", 32'(bus.rd_val), 32'd0);
        cyc(0, 1, 8'h74, 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 0, 0);
        chk("clr.rdy", 32'(bus.frm_rdy), 32'd0);
        chk("clr.fc", 32'(bus.frm_cnt), 32'd6);

        // Gapped reads.
        burst(3, 8'h81);
        cyc(0, 0, 8'h00, 0, 1);
        chk("gap.rv0", 32'(bus.rd_val), 32'd1);
        chk("gap.d0", 32'(bus.rd_dat), 32'h81);
        cyc(0, 0, 8'h00, 0, 0);
        chk("gap.rv1", 32'(bus.rd_val), 32'd0);
        cyc(0, 0, 8'h00, 0, 0);
        chk("gap.d2", 32'(bus.rd_dat), 32'h81);
        cyc(0, 0, 8'h00, 0, 1);
        chk("gap.d3", 32'(bus.rd_dat), 32'h82);
        cyc(0, 0, 8'h00, 0, 1);
        chk("gap.d4", 32'(bus.rd_dat), 32'h83);
        cyc(0, 0, 8'h00, 0, 1);
        chk("gap.empty", 32'(bus.rd_val), 32'd0);

        // Reset mid-readout.
        burst(3, 8'h91);
        cyc(0, 0, 8'h00, 0, 1);
        cyc(1, 0, 8'h00, 0, 1);
        chk("rst.rdy", 32'(bus.frm_rdy), 32'd0);
        chk("rst.len", 32'(bus.frm_len), 32'd0);
        chk("rst.rv", 32'(bus.rd_val), 32'd0);
        chk("rst.dat", 32'(bus.rd_dat), 32'd0);
        chk("rst.fc", 32'(bus.frm_cnt), 32'd0);

        // Randomized traffic against the model.
        v_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) v_r = !v_r;
            cyc(($urandom_range(0, 799) == 0),
                v_r,
                8'($urandom),
                ($urandom_range(0, 99) == 0),
                ($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
